// File: rtl/demux_stream_pkg.sv
// Shared constants and helpers for the 1-to-NCH stream demultiplexer.
package demux_stream_pkg;

   localparam int DROP_CNT_W = 16;

   typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

   localparam drop_cnt_t DROP_CNT_MAX = '1;

   // True when a select value addresses an existing channel.
   function automatic logic sel_in_range(input int unsigned sel, input int unsigned nch);
      return sel < nch;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register stage: loads when told to, clears when drained,
// otherwise holds its payload stable for the consumer.
module demux_slot
   import demux_stream_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             drain_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Next slot state: a load wins over a drain so drain+reload keeps valid high.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && drain_ready) begin
         valid_d = 1'b0;
      end
   end

   // Slot register; contents are discarded on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-NCH stream demultiplexer with broadcast and
// out-of-range select dropping.
module demux_stream
   import demux_stream_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NCH   = 4,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [SELW-1:0]       in_sel,
   input  logic                  in_bcast,
   output logic [NCH-1:0]        out_valid,
   input  logic [NCH-1:0]        out_ready,
   output logic [NCH*WIDTH-1:0]  out_data,
   output logic                  err_sel,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   logic [NCH-1:0] slot_free;
   logic           sel_ok;
   logic           sel_free;
   logic           accept;
   logic           drop;
   logic [NCH-1:0] load;

   logic      err_sel_q, err_sel_d;
   drop_cnt_t drop_cnt_q, drop_cnt_d;

   // Readiness: broadcast needs every slot free, unicast only its target,
   // and an out-of-range select is always taken (and thrown away).
   always_comb begin
      slot_free = '0;
      sel_free  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         slot_free[i] = !out_valid[i] || out_ready[i];
         if (in_sel == SELW'(i)) sel_free = slot_free[i];
      end
      sel_ok = sel_in_range(32'(in_sel), NCH);
      if (!rst_n)        in_ready = 1'b0;
      else if (in_bcast) in_ready = &slot_free;
      else if (sel_ok)   in_ready = sel_free;
      else               in_ready = 1'b1;
   end

   // Load decode for the slots and drop detection for bad selects.
   always_comb begin
      accept = in_valid && in_ready;
      drop   = accept && !in_bcast && !sel_ok;
      load   = '0;
      for (int i = 0; i < NCH; i++) begin
         load[i] = accept && (in_bcast || (sel_ok && (in_sel == SELW'(i))));
      end
   end

   // Error pulse follows each drop; drop counter sticks at its maximum.
   always_comb begin
      err_sel_d  = drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != DROP_CNT_MAX)) drop_cnt_d = drop_cnt_q + 1'b1;
   end

   // Error and drop-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sel_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         err_sel_q  <= err_sel_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign err_sel  = err_sel_q;
   assign drop_cnt = drop_cnt_q;

   for (genvar g = 0; g < NCH; g++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .load        (load[g]),
         .drain_ready (out_ready[g]),
         .load_data   (in_data),
         .valid       (out_valid[g]),
         .data        (out_data[g*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // four-channel instance
   logic        a_in_valid = 0, a_in_bcast = 0, a_in_ready;
   logic [7:0]  a_in_data = 0;
   logic [1:0]  a_in_sel = 0;
   logic [3:0]  a_out_valid, a_out_ready = 4'hF;
   logic [31:0] a_out_data;
   logic        a_err_sel;
   logic [15:0] a_drop_cnt;

   // three-channel instance (select value 3 is out of range)
   logic        b_in_valid = 0, b_in_ready;
   logic [7:0]  b_in_data = 0;
   logic [1:0]  b_in_sel = 0;
   logic [2:0]  b_out_valid;
   logic [23:0] b_out_data;
   logic        b_err_sel;
   logic [15:0] b_drop_cnt;

   demux_stream #(.WIDTH(8), .NCH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_sel(a_in_sel), .in_bcast(a_in_bcast),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .err_sel(a_err_sel), .drop_cnt(a_drop_cnt));

   demux_stream #(.WIDTH(8), .NCH(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(1'b0),
      .out_valid(b_out_valid), .out_ready(3'b111), .out_data(b_out_data),
      .err_sel(b_err_sel), .drop_cnt(b_drop_cnt));

   int errors = 0;
   int checks = 0;
   logic [7:0] q [4][$];
   logic       mon_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one transfer to the four-channel instance, push its expectation on acceptance.
   task automatic send_a(input logic [7:0] d, input logic [1:0] s, input logic b);
      int n;
      n = 0;
      a_in_valid = 1'b1; a_in_data = d; a_in_sel = s; a_in_bcast = b;
      @(negedge clk);
      while (!a_in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (!a_in_ready) begin
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 (data %0h)", d);
      end else if (b) begin
         for (int i = 0; i < 4; i++) q[i].push_back(d);
      end else begin
         q[s].push_back(d);
      end
      tick();
      a_in_valid = 1'b0; a_in_bcast = 1'b0;
   endtask

   // Monitor: every handshake on the four-channel instance must match the queue head.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         for (int i = 0; i < 4; i++) begin
            if (a_out_valid[i] && a_out_ready[i]) begin
               checks++;
               if (q[i].size() == 0) begin
                  errors++;
                  $display("FAIL mon_unexpected ch%0d: got %0h expected nothing", i, a_out_data[i*8 +: 8]);
               end else begin
                  logic [7:0] e;
                  e = q[i].pop_front();
                  if (a_out_data[i*8 +: 8] !== e) begin
                     errors++;
                     $display("FAIL mon_data ch%0d: got %0h expected %0h", i, a_out_data[i*8 +: 8], e);
                  end
               end
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset: toggle inputs while held
      for (int i = 0; i < 4; i++) begin
         a_in_valid = i[0]; a_in_data = 8'(i * 37); a_in_sel = i[1:0];
         b_in_valid = ~i[0]; b_in_sel = 2'd3;
         tick();
      end
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_data", a_out_data, 0);
      chk("rst_a_ready", a_in_ready, 0);
      chk("rst_b_ready", b_in_ready, 0);
      chk("rst_b_err", b_err_sel, 0);
      chk("rst_b_drop", b_drop_cnt, 0);
      a_in_valid = 0; b_in_valid = 0; a_in_sel = 0; b_in_sel = 0;
      rst_n = 1'b1;
      #1;
      chk("rel_a_ready", a_in_ready, 1);
      tick();

      // unicast steering
      a_out_ready = 4'hF;
      send_a(8'hA5, 2'd2, 1'b0);
      chk("uni_valid", a_out_valid, 4'b0100);
      chk("uni_data", a_out_data[23:16], 8'hA5);
      for (int s = 0; s < 4; s++) begin
         send_a(8'(8'h10 + s), 2'(s), 1'b0);
         chk("sweep_valid", a_out_valid, 32'(1 << s));
      end
      tick();
      chk("sweep_drained", a_out_valid, 0);

      // backpressure on channel 1
      a_out_ready = 4'b1101;
      send_a(8'h11, 2'd1, 1'b0);
      chk("bp_first", a_out_data[15:8], 8'h11);
      a_in_valid = 1'b1; a_in_data = 8'h22; a_in_sel = 2'd1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_ready_low", a_in_ready, 0);
         tick();
         chk("bp_hold", {a_out_valid[1], a_out_data[15:8]}, {1'b1, 8'h11});
      end
      a_out_ready = 4'hF;
      send_a(8'h22, 2'd1, 1'b0);
      chk("bp_second", {a_out_valid[1], a_out_data[15:8]}, {1'b1, 8'h22});
      tick();

      // broadcast waits for the stalled channel 2
      a_out_ready = 4'b1011;
      send_a(8'h77, 2'd2, 1'b0);
      a_in_valid = 1'b1; a_in_data = 8'h3C; a_in_bcast = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bc_ready_low", a_in_ready, 0);
         tick();
         chk("bc_no_partial", a_out_valid, 4'b0100);
      end
      a_out_ready = 4'hF;
      send_a(8'h3C, 2'd0, 1'b1);
      chk("bc_valid", a_out_valid, 4'hF);
      chk("bc_data", a_out_data, 32'h3C3C3C3C);
      tick();

      // drain+reload every cycle on channel 0
      for (int k = 0; k < 16; k++) begin
         send_a(8'($urandom_range(0, 255)), 2'd0, 1'b0);
         chk("stream_valid", a_out_valid[0], 1);
      end
      tick();
      chk("stream_drained", a_out_valid, 0);
      tick();
      for (int i = 0; i < 4; i++) chk("queue_empty", q[i].size(), 0);

      // out-of-range select on the three-channel instance
      b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hEE;
      @(negedge clk);
      chk("oor_ready", b_in_ready, 1);
      tick();
      b_in_valid = 1'b0;
      chk("oor_err", b_err_sel, 1);
      chk("oor_cnt", b_drop_cnt, 1);
      chk("oor_no_out", b_out_valid, 0);
      tick();
      chk("oor_err_pulse", b_err_sel, 0);
      b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 8'h5A;
      tick();
      b_in_valid = 1'b0;
      chk("b_uni", {b_out_valid, b_out_data[23:16]}, {3'b100, 8'h5A});
      chk("b_uni_cnt", {b_err_sel, b_drop_cnt}, {1'b0, 16'd1});

      // back-to-back drops, then saturation
      b_in_valid = 1'b1; b_in_sel = 2'd3;
      tick();
      tick();
      chk("b2b_err", b_err_sel, 1);
      chk("b2b_cnt", b_drop_cnt, 3);
      repeat (65600) tick();
      chk("sat_cnt", b_drop_cnt, 16'hFFFF);
      b_in_valid = 1'b0;
      tick();
      chk("sat_hold", {b_err_sel, b_drop_cnt}, {1'b0, 16'hFFFF});

      // reset in the middle of a held transfer
      a_out_ready = 4'h0;
      send_a(8'h99, 2'd3, 1'b0);
      chk("mid_loaded", a_out_valid, 4'b1000);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_valid", a_out_valid, 0);
      chk("mid_data", a_out_data, 0);
      chk("mid_drop", b_drop_cnt, 0);
      for (int i = 0; i < 4; i++) q[i].delete();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_valid", a_out_valid, 0);
      chk("post_err", b_err_sel, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
